// File: rtl/cwe1245_rr_arbiter.sv
// Four-requester round-robin arbiter with a hardened one-hot FSM.
// Grants are registered and one-hot. A hold limit revokes long grants.
// Illegal state or grant encodings set a sticky fault and return the FSM to IDLE.
module cwe1245_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout,
  output logic       fault
);

  // state | meaning
  // IDLE  | no grant; arbitrate on the next edge
  // GRANT | one requester owns the resource
  // 2'b00 and 2'b11 are illegal and are treated as a fault
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_t;

  localparam int CW = $clog2(MAX_HOLD + 1);

  state_t          state, state_n;
  logic [3:0]      grant_q, grant_n;
  logic [1:0]      owner_n;
  logic [1:0]      last, last_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            timeout_n;
  logic            fault_n;
  logic            busy_n;
  logic            found;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            grant_onehot;
  logic            fault_det;

  // The fault checker looks at the grant port itself, so any corruption
  // of the driven value is visible to it.
  assign grant = grant_q;

  // Round-robin search starting just after the most recent grantee.
  always_comb begin
    found  = 1'b0;
    winner = 2'b00;
    idx    = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Encoding checks on the state register and the visible grant.
  always_comb begin
    grant_onehot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    fault_det    = ((state != IDLE) && (state != GRANT)) ||
                   ((state == IDLE) && (grant != 4'b0000)) ||
                   ((state == GRANT) && !grant_onehot);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    owner_n   = owner;
    last_n    = last;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    fault_n   = fault;
    if (fault_det) begin
      state_n = IDLE;
      grant_n = 4'b0000;
      cnt_n   = '0;
      fault_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          grant_n = 4'b0000;
          if (found) begin
            state_n = GRANT;
            grant_n = 4'b0001 << winner;
            owner_n = winner;
            last_n  = winner;
            cnt_n   = CW'(1);
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            state_n = IDLE;
            grant_n = 4'b0000;
            cnt_n   = '0;
          end else if (cnt == CW'(MAX_HOLD)) begin
            state_n   = IDLE;
            grant_n   = 4'b0000;
            cnt_n     = '0;
            timeout_n = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          grant_n = 4'b0000;
          cnt_n   = '0;
        end
      endcase
    end
    busy_n = |grant_n;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= 4'b0000;
      owner   <= 2'b00;
      last    <= 2'b11;
      cnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      owner   <= owner_n;
      last    <= last_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      timeout <= timeout_n;
      fault   <= fault_n;
    end
  end

endmodule
